// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the mode-0 SPI master.
// Imported by spi_master and spi_clk_gen.
package spi_pkg;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam int CLK_DIV_MIN = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_XFER  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter: tick marks the last cycle of each CLK_DIV-long slot.
// phase is the SCK level of the current XFER half-period (first one is high).
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic load,
   output logic tick,
   output logic phase
);

   localparam int DIV = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;
   localparam int CW  = $clog2(DIV);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(DIV - 1));

   // Counter restarts on every state entry so no slot spans two states.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (load) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (tick) begin
         cnt   <= '0;
         phase <= ~phase;
      end else if (en) begin
         cnt   <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Single-transfer SPI master, mode 0, MSB first, all outputs registered.
// FSM: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              START,
   input  logic [1:0]        MODE,
   input  logic [DATA_W-1:0] TX_DATA,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic              SS,
   output logic              SCK,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int BW = $clog2(DATA_W) + 1;

   state_t            state;
   state_t            state_next;
   logic              tick;
   logic              phase;
   logic              en;
   logic              load;
   logic              last_half;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] rx_sh;
   logic [BW-1:0]     bit_cnt;

   logic ss_next;
   logic sck_next;
   logic mosi_next;
   logic busy_next;
   logic done_next;
   logic err_next;
   logic accept;
   logic capture;
   logic shift;
   logic update;

   assign en        = (state != ST_IDLE);
   assign load      = (state_next != state);
   assign last_half = (bit_cnt == BW'(DATA_W));

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk (
      .clk   (PCLK),
      .rst   (PRESET),
      .en    (en),
      .load  (load),
      .tick  (tick),
      .phase (phase)
   );

   // State register.
   always_ff @(posedge PCLK) begin
      if (PRESET) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state: XFER ends after the low half-period that follows the last fall.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  if (START && MODE == MODE0) state_next = ST_SETUP;
         ST_SETUP: if (tick) state_next = ST_XFER;
         ST_XFER:  if (tick && !phase && last_half) state_next = ST_HOLD;
         ST_HOLD:  if (tick) state_next = ST_GAP;
         ST_GAP:   if (tick) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Output decode: next values of the registered pins plus datapath strobes.
   always_comb begin
      ss_next   = SS;
      sck_next  = SCK;
      mosi_next = MOSI;
      busy_next = BUSY;
      done_next = 1'b0;
      err_next  = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      shift     = 1'b0;
      update    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (START && MODE == MODE0) begin
               accept    = 1'b1;
               ss_next   = 1'b0;
               busy_next = 1'b1;
               mosi_next = TX_DATA[DATA_W-1];
            end else if (START) begin
               err_next  = 1'b1;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               sck_next = 1'b1;
               capture  = 1'b1;
            end
         end
         ST_XFER: begin
            if (tick && phase) begin
               sck_next  = 1'b0;
               shift     = 1'b1;
               mosi_next = tx_sh[DATA_W-2];
            end else if (tick && !last_half) begin
               sck_next  = 1'b1;
               capture   = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tick) begin
               ss_next   = 1'b1;
               done_next = 1'b1;
               update    = 1'b1;
            end
         end
         ST_GAP: begin
            if (tick) busy_next = 1'b0;
         end
         default: begin
            ss_next   = 1'b1;
            sck_next  = 1'b0;
            mosi_next = 1'b0;
            busy_next = 1'b0;
         end
      endcase
   end

   // Pin registers, shift registers and falling-edge bit counter.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         SS      <= 1'b1;
         SCK     <= 1'b0;
         MOSI    <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         RX_DATA <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         bit_cnt <= '0;
      end else begin
         SS   <= ss_next;
         SCK  <= sck_next;
         MOSI <= mosi_next;
         BUSY <= busy_next;
         DONE <= done_next;
         ERR  <= err_next;
         if (accept) begin
            tx_sh   <= TX_DATA;
            bit_cnt <= '0;
         end else if (shift) begin
            tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (capture) rx_sh <= {rx_sh[DATA_W-2:0], MISO};
         if (update) RX_DATA <= rx_sh;
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table of transfers against a mode-0 slave model,
// plus hand-written error, reset, back-to-back and CLK_DIV=2 sequences.
module tb_spi_master;

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;

   logic       start_a = 1'b0;
   logic [1:0] mode_a = 2'b00;
   logic [7:0] tx_a = 8'h00;
   logic [7:0] rx_a;
   logic       busy_a, done_a, err_a, ss_a, sck_a, mosi_a, miso_a;

   logic       start_b = 1'b0;
   logic [1:0] mode_b = 2'b00;
   logic [7:0] tx_b = 8'h00;
   logic [7:0] rx_b;
   logic       busy_b, done_b, err_b, ss_b, sck_b, mosi_b, miso_b;

   int n_checks = 0;
   int n_fail = 0;

   always #5 PCLK = ~PCLK;

   spi_master #(.DATA_W(8), .CLK_DIV(4)) dut_a (
      .PCLK(PCLK), .PRESET(PRESET), .START(start_a), .MODE(mode_a),
      .TX_DATA(tx_a), .RX_DATA(rx_a), .BUSY(busy_a), .DONE(done_a),
      .ERR(err_a), .SS(ss_a), .SCK(sck_a), .MOSI(mosi_a), .MISO(miso_a)
   );

   spi_master #(.DATA_W(8), .CLK_DIV(2)) dut_b (
      .PCLK(PCLK), .PRESET(PRESET), .START(start_b), .MODE(mode_b),
      .TX_DATA(tx_b), .RX_DATA(rx_b), .BUSY(busy_b), .DONE(done_b),
      .ERR(err_b), .SS(ss_b), .SCK(sck_b), .MOSI(mosi_b), .MISO(miso_b)
   );

   // Mode-0 slave models: load on SS fall, shift out on SCK fall.
   logic [7:0] byte_a = 8'h00, sl_a = 8'h00;
   logic       ssq_a = 1'b1, sckq_a = 1'b0;
   logic [7:0] byte_b = 8'h00, sl_b = 8'h00;
   logic       ssq_b = 1'b1, sckq_b = 1'b0;

   always @(posedge PCLK) begin
      ssq_a  <= ss_a;
      sckq_a <= sck_a;
      if (ssq_a && !ss_a) sl_a <= byte_a;
      else if (sckq_a && !sck_a && !ss_a) sl_a <= {sl_a[6:0], 1'b0};
   end

   always @(posedge PCLK) begin
      ssq_b  <= ss_b;
      sckq_b <= sck_b;
      if (ssq_b && !ss_b) sl_b <= byte_b;
      else if (sckq_b && !sck_b && !ss_b) sl_b <= {sl_b[6:0], 1'b0};
   end

   assign miso_a = sl_a[7];
   assign miso_b = sl_b[7];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   int         n_done, n_rise, n_err, done_cyc, idle_cyc, r1, r2;
   logic [7:0] mosi_byte;

   // One transfer; start is optionally re-pulsed at cycle pulse_at,
   // TX/MODE are scrambled while busy to show they are ignored.
   task automatic run_xfer(input bit b, input logic [7:0] tx,
                           input logic [7:0] sl, input int pulse_at);
      logic ss, sck, mosi, busy, done, err, prev;
      int   n;
      @(negedge PCLK);
      if (b) begin tx_b = tx; byte_b = sl; start_b = 1'b1; end
      else   begin tx_a = tx; byte_a = sl; start_a = 1'b1; end
      n = 0; n_done = 0; n_rise = 0; n_err = 0;
      done_cyc = -1; idle_cyc = -1; r1 = -1; r2 = -1;
      mosi_byte = 8'h00; prev = 1'b0;
      while (n < 400 && idle_cyc < 0) begin
         @(posedge PCLK); #1;
         n++;
         ss   = b ? ss_b   : ss_a;
         sck  = b ? sck_b  : sck_a;
         mosi = b ? mosi_b : mosi_a;
         busy = b ? busy_b : busy_a;
         done = b ? done_b : done_a;
         err  = b ? err_b  : err_a;
         if (n == 1) begin
            check("ss_low_cycle1", ss, 0);
            check("busy_cycle1", busy, 1);
            check("mosi_msb_cycle1", mosi, tx[7]);
         end
         if (sck && !prev) begin
            n_rise++;
            mosi_byte = {mosi_byte[6:0], mosi};
            if (r1 < 0) r1 = n;
            else if (r2 < 0) r2 = n;
         end
         prev = sck;
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = n;
         end
         if (err) n_err++;
         if (n > 1 && !busy) idle_cyc = n;
         if (b) start_b = (n == pulse_at - 1);
         else   start_a = (n == pulse_at - 1);
         if (n == 1) begin
            if (b) begin tx_b = ~tx; mode_b = 2'b01; end
            else   begin tx_a = ~tx; mode_a = 2'b01; end
         end
         if (!busy) begin mode_a = 2'b00; mode_b = 2'b00; end
      end
      mode_a = 2'b00;
      mode_b = 2'b00;
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] sl;
      int         pulse;
      logic [7:0] exp_rx;
      logic [7:0] exp_mosi;
      int         exp_done;
      int         exp_idle;
      int         exp_rise;
      int         exp_dones;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int         cnt, n_fall, hi_run, gap_len, d1, d2;
      logic [15:0] mb;
      logic [7:0] rx1, rx2;
      logic       prev_ss, prev_sck;

      vecs[0] = '{8'hA5, 8'h3C, 0,  8'h3C, 8'hA5, 73, 77, 8, 1};
      vecs[1] = '{8'h00, 8'hFF, 0,  8'hFF, 8'h00, 73, 77, 8, 1};
      vecs[2] = '{8'hFF, 8'h00, 20, 8'h00, 8'hFF, 73, 77, 8, 1};
      vecs[3] = '{8'h81, 8'h7E, 0,  8'h7E, 8'h81, 73, 77, 8, 1};
      vecs[4] = '{8'h5A, 8'hC3, 0,  8'hC3, 8'h5A, 73, 77, 8, 1};

      // Reset values
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      PRESET = 1'b0;
      check("rst_ss", ss_a, 1);
      check("rst_sck", sck_a, 0);
      check("rst_mosi", mosi_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_err", err_a, 0);
      check("rst_rx", rx_a, 0);

      // Unsupported mode: one ERR pulse, bus untouched
      @(negedge PCLK);
      mode_a = 2'b01;
      start_a = 1'b1;
      @(posedge PCLK); #1;
      check("err_pulse", err_a, 1);
      check("err_ss", ss_a, 1);
      check("err_sck", sck_a, 0);
      check("err_mosi", mosi_a, 0);
      check("err_busy", busy_a, 0);
      start_a = 1'b0;
      mode_a = 2'b00;
      @(posedge PCLK); #1;
      check("err_one_cycle", err_a, 0);
      check("err_busy_after", busy_a, 0);
      check("err_ss_after", ss_a, 1);

      // Table of single transfers
      for (int i = 0; i < 5; i++) begin
         run_xfer(1'b0, vecs[i].tx, vecs[i].sl, vecs[i].pulse);
         check("rx_data", rx_a, vecs[i].exp_rx);
         check("mosi_bits", mosi_byte, vecs[i].exp_mosi);
         check("done_cycle", done_cyc, vecs[i].exp_done);
         check("busy_fall_cycle", idle_cyc, vecs[i].exp_idle);
         check("sck_rises", n_rise, vecs[i].exp_rise);
         check("done_count", n_done, vecs[i].exp_dones);
         check("no_err", n_err, 0);
      end

      // Reset in the middle of a transfer
      @(negedge PCLK);
      tx_a = 8'hA5;
      byte_a = 8'h3C;
      start_a = 1'b1;
      for (int n = 1; n <= 39; n++) begin
         @(posedge PCLK); #1;
         if (n == 1) start_a = 1'b0;
      end
      check("pre_reset_ss", ss_a, 0);
      check("pre_reset_rx", rx_a, 8'hC3);
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      check("midrst_ss", ss_a, 1);
      check("midrst_sck", sck_a, 0);
      check("midrst_busy", busy_a, 0);
      check("midrst_rx", rx_a, 0);
      check("midrst_mosi", mosi_a, 0);
      check("midrst_done", done_a, 0);
      PRESET = 1'b0;
      cnt = 0;
      repeat (100) begin
         @(posedge PCLK); #1;
         if (done_a || !ss_a || busy_a) cnt++;
      end
      check("midrst_quiet", cnt, 0);

      // START held high: two back-to-back transfers
      @(negedge PCLK);
      tx_a = 8'hFF;
      byte_a = 8'h96;
      start_a = 1'b1;
      n_fall = 0; hi_run = 0; gap_len = -1; d1 = -1; d2 = -1;
      mb = 16'h0000; rx1 = 8'h00; rx2 = 8'h00; cnt = 0;
      prev_ss = 1'b1; prev_sck = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge PCLK); #1;
         if (n == 1) tx_a = 8'h00;
         if (n == 2) byte_a = 8'h69;
         if (sck_a && !prev_sck) mb = {mb[14:0], mosi_a};
         prev_sck = sck_a;
         if (ss_a) hi_run++;
         if (!ss_a && prev_ss) begin
            n_fall++;
            if (n_fall == 2) begin
               gap_len = hi_run;
               start_a = 1'b0;
            end
         end
         if (!ss_a) hi_run = 0;
         prev_ss = ss_a;
         if (done_a) begin
            cnt++;
            if (d1 < 0) begin d1 = n; rx1 = rx_a; end
            else if (d2 < 0) begin d2 = n; rx2 = rx_a; end
         end
      end
      check("b2b_done1", d1, 73);
      check("b2b_done2", d2, 150);
      check("b2b_rx1", rx1, 8'h96);
      check("b2b_rx2", rx2, 8'h69);
      check("b2b_mosi", mb, 16'hFF00);
      check("b2b_gap", gap_len, 5);
      check("b2b_dones", cnt, 2);
      check("b2b_idle", busy_a, 0);

      // CLK_DIV = 2
      run_xfer(1'b1, 8'h81, 8'h5C, 0);
      check("div2_done", done_cyc, 37);
      check("div2_busy_fall", idle_cyc, 39);
      check("div2_rx", rx_b, 8'h5C);
      check("div2_mosi", mosi_byte, 8'h81);
      check("div2_rises", n_rise, 8);
      check("div2_sck_period", r2 - r1, 4);
      check("div2_dones", n_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
